// File: rtl/updi_uart_8e2.sv
// updi_uart_8e2: single-wire half-duplex UART for the UPDI pad, 8E2 framing
// (start, 8 data bits LSB-first, even parity, 2 stop bits). TX and RX share one FSM.
//
// Optional feature macro: UPDI_UART_ECHO_CHECK_EN
//   defined   : TX echo is compared against the driven bit at each mid-bit and
//               o_tx_collision pulses when the pad is released after a mismatch.
//   undefined : o_tx_collision is tied low; the pad is not observed during TX.
//
// Ports:
//   i_clk, i_rst       clock; synchronous active-high reset
//   i_tx_data/valid    byte to send; o_tx_ready accepts on i_tx_valid & o_tx_ready
//   o_rx_data/valid    received byte with 1-cycle valid pulse
//   o_rx_parity_err    qualifies o_rx_valid: parity mismatch
//   o_rx_frame_err     qualifies o_rx_valid: a stop bit sampled low
//   o_rx_break         1-cycle pulse: all 12 bit samples low
//   o_tx_collision     1-cycle pulse at TX frame end when echo mismatched
//   o_busy             FSM not idle
//   o_updi_oe/out      pad output enable / drive value
//   i_updi_in          asynchronous pad input
module updi_uart_8e2 #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_rx_parity_err,
  output logic       o_rx_frame_err,
  output logic       o_rx_break,
  output logic       o_tx_collision,
  output logic       o_busy,
  output logic       o_updi_oe,
  output logic       o_updi_out,
  input  logic       i_updi_in
);

  localparam int unsigned CNT_BITS = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = CNT_BITS'(CLKS_PER_BIT - 1);
  localparam logic [CNT_BITS-1:0] CNT_HALF = CNT_BITS'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    StIdle,
    StTxBits,
    StRxStart,
    StRxBits,
    StRxWaitIdle
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_sync1, r_sync2;
  logic [CNT_BITS-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]          r_bit, w_bit_nxt;
  logic [11:0]         r_tx_shift, w_tx_shift_nxt;
  logic [10:0]         r_rx_shift, w_rx_shift_nxt;
  logic                r_oe, w_oe_nxt;
  logic                r_out, w_out_nxt;
  logic [7:0]          r_rx_data, w_rx_data_nxt;
  logic                r_rx_valid, w_rx_valid_nxt;
  logic                r_par_err, w_par_err_nxt;
  logic                r_frm_err, w_frm_err_nxt;
  logic                r_break, w_break_nxt;
  logic                r_busy;

  logic                w_sync_in;
  logic                w_tx_ready;
  logic                w_accept;
  logic                w_tx_release;
  logic [10:0]         w_rx_frame;

  assign w_sync_in    = r_sync2;
  assign w_tx_ready   = (r_state == StIdle) & w_sync_in & ~i_rst;
  assign w_accept     = i_tx_valid & w_tx_ready;
  // The frame is released one full bit after the last (stop2) bit started driving.
  assign w_tx_release = (r_state == StTxBits) && (r_cnt == '0) && (r_bit == 4'd12);
  // Shifter contents as they will be after the current sample is taken.
  assign w_rx_frame   = {w_sync_in, r_rx_shift[10:1]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_tx_shift <= '1;
      r_rx_shift <= '0;
      r_oe       <= 1'b0;
      r_out      <= 1'b1;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_par_err  <= 1'b0;
      r_frm_err  <= 1'b0;
      r_break    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sync1    <= i_updi_in;
      r_sync2    <= r_sync1;
      r_cnt      <= w_cnt_nxt;
      r_bit      <= w_bit_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_oe       <= w_oe_nxt;
      r_out      <= w_out_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_par_err  <= w_par_err_nxt;
      r_frm_err  <= w_frm_err_nxt;
      r_break    <= w_break_nxt;
      r_busy     <= (w_state_nxt != StIdle);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_bit_nxt      = r_bit;
    w_tx_shift_nxt = r_tx_shift;
    w_rx_shift_nxt = r_rx_shift;
    w_oe_nxt       = r_oe;
    w_out_nxt      = r_out;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = 1'b0;
    w_par_err_nxt  = 1'b0;
    w_frm_err_nxt  = 1'b0;
    w_break_nxt    = 1'b0;

    unique case (r_state)
      StIdle: begin
        w_oe_nxt  = 1'b0;
        w_out_nxt = 1'b1;
        w_cnt_nxt = '0;
        w_bit_nxt = '0;
        if (w_accept) begin
          w_tx_shift_nxt = {2'b11, ^i_tx_data, i_tx_data, 1'b0};
          w_state_nxt    = StTxBits;
        end else if (!w_sync_in) begin
          w_state_nxt = StRxStart;
        end
      end

      StTxBits: begin
        w_cnt_nxt = (r_cnt == CNT_MAX) ? '0 : r_cnt + 1'b1;
        // A new bit goes onto the pad each time the timer is at zero.
        if (r_cnt == '0) begin
          if (w_tx_release) begin
            w_oe_nxt    = 1'b0;
            w_out_nxt   = 1'b1;
            w_state_nxt = StIdle;
          end else begin
            w_oe_nxt       = 1'b1;
            w_out_nxt      = r_tx_shift[0];
            w_tx_shift_nxt = {1'b1, r_tx_shift[11:1]};
            w_bit_nxt      = r_bit + 1'b1;
          end
        end
      end

      StRxStart: begin
        if (r_cnt == CNT_HALF) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = w_sync_in ? StIdle : StRxBits;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      StRxBits: begin
        if (r_cnt == CNT_MAX) begin
          w_cnt_nxt      = '0;
          w_rx_shift_nxt = w_rx_frame;
          w_bit_nxt      = r_bit + 1'b1;
          // Stop2 sample lands mid-bit, so the FSM is ready half a bit early.
          if (r_bit == 4'd10) begin
            if (w_rx_frame == '0) begin
              w_break_nxt = 1'b1;
              w_state_nxt = StRxWaitIdle;
            end else begin
              w_rx_valid_nxt = 1'b1;
              w_rx_data_nxt  = w_rx_frame[7:0];
              w_par_err_nxt  = ^w_rx_frame[8:0];
              w_frm_err_nxt  = ~(w_rx_frame[9] & w_rx_frame[10]);
              w_state_nxt    = w_rx_frame[10] ? StIdle : StRxWaitIdle;
            end
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      StRxWaitIdle: begin
        // Counts consecutive high cycles; any low restarts the count.
        if (!w_sync_in) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_cnt_nxt   = '0;
          w_state_nxt = StIdle;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

`ifdef UPDI_UART_ECHO_CHECK_EN
  localparam logic [CNT_BITS-1:0] CNT_MID = CNT_BITS'(CLKS_PER_BIT / 2);

  // Two-stage copy of the driven value lines up with the synchroniser delay.
  logic r_out_d1, r_out_d2;
  logic r_collide, w_collide_nxt;
  logic r_tx_collision, w_tx_collision_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_d1       <= 1'b1;
      r_out_d2       <= 1'b1;
      r_collide      <= 1'b0;
      r_tx_collision <= 1'b0;
    end else begin
      r_out_d1       <= r_out;
      r_out_d2       <= r_out_d1;
      r_collide      <= w_collide_nxt;
      r_tx_collision <= w_tx_collision_nxt;
    end
  end

  always_comb begin
    w_collide_nxt      = r_collide;
    w_tx_collision_nxt = 1'b0;
    if (r_state == StIdle) begin
      w_collide_nxt = 1'b0;
    end
    if ((r_state == StTxBits) && (r_cnt == CNT_MID) && (r_bit != 4'd0) &&
        (w_sync_in != r_out_d2)) begin
      w_collide_nxt = 1'b1;
    end
    if (w_tx_release) begin
      w_tx_collision_nxt = r_collide;
    end
  end

  assign o_tx_collision = r_tx_collision;
`else
  assign o_tx_collision = 1'b0;
`endif

  assign o_tx_ready      = w_tx_ready;
  assign o_rx_data       = r_rx_data;
  assign o_rx_valid      = r_rx_valid;
  assign o_rx_parity_err = r_par_err;
  assign o_rx_frame_err  = r_frm_err;
  assign o_rx_break      = r_break;
  assign o_busy          = r_busy;
  assign o_updi_oe       = r_oe;
  assign o_updi_out      = r_out;

endmodule

// File: tb/tb_updi_uart_8e2.sv
// Directed bench for updi_uart_8e2 at 16 clocks per bit. A pad model resolves
// the shared line (DUT drive when enabled, otherwise the bench's RX driver).
module tb_updi_uart_8e2;

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_parity_err;
  logic       rx_frame_err;
  logic       rx_break;
  logic       tx_collision;
  logic       busy;
  logic       updi_oe;
  logic       updi_out;
  logic       updi_in;

  logic       rx_drv;
  logic       force_low;
  logic       pad;

  assign pad     = updi_oe ? updi_out : rx_drv;
  assign updi_in = force_low ? 1'b0 : pad;

  updi_uart_8e2 #(.CLKS_PER_BIT(16)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_tx_data      (tx_data),
    .i_tx_valid     (tx_valid),
    .o_tx_ready     (tx_ready),
    .o_rx_data      (rx_data),
    .o_rx_valid     (rx_valid),
    .o_rx_parity_err(rx_parity_err),
    .o_rx_frame_err (rx_frame_err),
    .o_rx_break     (rx_break),
    .o_tx_collision (tx_collision),
    .o_busy         (busy),
    .o_updi_oe      (updi_oe),
    .o_updi_out     (updi_out),
    .i_updi_in      (updi_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_accept = 0;
  int accept_cyc = -1;

  // Pulse monitor on the opposite edge.
  int         n_valid = 0;
  int         n_break = 0;
  int         n_coll  = 0;
  int         valid_cyc = -1;
  logic [7:0] last_data = '0;
  logic       last_perr = 1'b0;
  logic       last_ferr = 1'b0;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      n_valid++;
      valid_cyc = cyc;
      last_data = rx_data;
      last_perr = rx_parity_err;
      last_ferr = rx_frame_err;
    end
    if (rx_break === 1'b1) n_break++;
    if (tx_collision === 1'b1) n_coll++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock; drops tx_valid right after the edge that accepted it.
  task automatic tick();
    logic acc;
    acc = tx_valid & tx_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      tx_valid   = 1'b0;
      accept_cyc = cyc;
      n_accept++;
    end
  endtask

  task automatic drive_frame(input logic [11:0] frame);
    for (int i = 0; i < 12; i++) begin
      rx_drv = frame[i];
      repeat (16) tick();
    end
    rx_drv = 1'b1;
  endtask

  // Called just after the accept edge; checks the full pad waveform.
  task automatic check_tx(input logic [11:0] frame);
    int errs;
    errs = 0;
    check("tx oe before first bit", updi_oe, 1'b0);
    for (int k = 0; k < 192; k++) begin
      tick();
      if (updi_oe !== 1'b1 || updi_out !== frame[k / 16]) errs++;
      if (k % 16 == 8) check($sformatf("tx bit %0d", k / 16), updi_out, frame[k / 16]);
    end
    check("tx waveform errors", errs, 0);
    check("tx_ready low in last bit", tx_ready, 1'b0);
    tick();
    check("tx oe released", updi_oe, 1'b0);
    check("tx out idle high", updi_out, 1'b1);
    check("tx_ready back at +193", tx_ready, 1'b1);
  endtask

  task automatic wait_oe_low(input string tag);
    int n;
    n = 0;
    while (updi_oe !== 1'b0 && n < 400) begin
      tick();
      n++;
    end
    check(tag, updi_oe, 1'b0);
  endtask

  int v0, b0, c0;

  initial begin
    rst = 1'b1; tx_data = '0; tx_valid = 1'b0; rx_drv = 1'b1; force_low = 1'b0;
    repeat (3) tick();
    check("reset oe", updi_oe, 1'b0);
    check("reset out", updi_out, 1'b1);
    check("reset busy", busy, 1'b0);
    check("reset rx_data", rx_data, 8'h00);
    check("reset pulses", {rx_valid, rx_break, tx_collision}, 3'b000);
    check("tx_ready low in reset", tx_ready, 1'b0);
    rst = 1'b0;
    repeat (3) tick();
    check("tx_ready after reset", tx_ready, 1'b1);

    // 1: transmit 0x55
    v0 = n_valid; c0 = n_coll;
    tx_data = 8'h55; tx_valid = 1'b1;
    tick();
    check("tx accepted", n_accept, 1);
    check("busy in tx", busy, 1'b1);
    check_tx(12'hCAA);
    check("no rx from own echo", n_valid - v0, 0);
    check("no collision on clean tx", n_coll - c0, 0);

    // 2: good byte 0xC3
    repeat (5) tick();
    v0 = n_valid;
    drive_frame(12'hD86);
    check("rx C3 count", n_valid - v0, 1);
    check("rx C3 data", last_data, 8'hC3);
    check("rx C3 perr", last_perr, 1'b0);
    check("rx C3 ferr", last_ferr, 1'b0);
    check("rx C3 idle", busy, 1'b0);

    // 3a: 0x01 with wrong parity
    repeat (5) tick();
    v0 = n_valid;
    drive_frame(12'hC02);
    check("rx perr count", n_valid - v0, 1);
    check("rx perr data", last_data, 8'h01);
    check("rx perr flag", last_perr, 1'b1);
    check("rx perr ferr", last_ferr, 1'b0);

    // 3b: stop2 low -> frame error, then wait for line idle
    repeat (5) tick();
    v0 = n_valid;
    drive_frame(12'h602);
    check("rx ferr count", n_valid - v0, 1);
    check("rx ferr flag", last_ferr, 1'b1);
    check("rx ferr perr", last_perr, 1'b0);
    check("rx ferr waiting", busy, 1'b1);
    repeat (17) tick();
    check("rx ferr still waiting", busy, 1'b1);
    tick();
    check("rx ferr idle after 16 high", busy, 1'b0);

    // 4: break, 24 bit times low
    repeat (5) tick();
    v0 = n_valid; b0 = n_break;
    rx_drv = 1'b0;
    repeat (300) tick();
    check("break busy while low", busy, 1'b1);
    repeat (84) tick();
    rx_drv = 1'b1;
    check("break pulses", n_break - b0, 1);
    check("break no valid", n_valid - v0, 0);
    repeat (17) tick();
    check("break still waiting", busy, 1'b1);
    tick();
    check("break idle after 16 high", busy, 1'b0);

    // 5a: 5-cycle glitch
    repeat (5) tick();
    v0 = n_valid; b0 = n_break;
    rx_drv = 1'b0;
    repeat (4) tick();
    check("glitch seen as start", busy, 1'b1);
    tick();
    rx_drv = 1'b1;
    repeat (20) tick();
    check("glitch back idle", busy, 1'b0);
    check("glitch no output", (n_valid - v0) + (n_break - b0), 0);

    // 5b: tx_valid together with a start edge -> RX first, then TX
    repeat (5) tick();
    v0 = n_valid; c0 = n_accept;
    rx_drv = 1'b0;
    tick();
    tick();
    tx_data = 8'h3C; tx_valid = 1'b1;
    check("rx priority ready", tx_ready, 1'b0);
    repeat (14) tick();
    for (int i = 1; i < 12; i++) begin
      rx_drv = (i == 9) ? 1'b0 : ((i >= 10) ? 1'b1 : ((8'hA5 >> (i - 1)) & 8'h01) != 0);
      repeat (16) tick();
    end
    rx_drv = 1'b1;
    check("prio rx count", n_valid - v0, 1);
    check("prio rx data", last_data, 8'hA5);
    check("prio tx accepted once", n_accept - c0, 1);
    check("prio tx after rx", accept_cyc - valid_cyc, 1);
    wait_oe_low("prio tx ends");
    check("prio tx_ready back", tx_ready, 1'b1);
    check("prio no echo rx", n_valid - v0, 1);

    // 6: reset in the middle of bit 5
    repeat (5) tick();
    v0 = n_valid;
    tx_data = 8'h55; tx_valid = 1'b1;
    tick();
    repeat (84) tick();
    check("mid-tx oe", updi_oe, 1'b1);
    rst = 1'b1;
    #1;
    check("tx_ready low under rst", tx_ready, 1'b0);
    tick();
    check("rst releases oe", updi_oe, 1'b0);
    check("rst out high", updi_out, 1'b1);
    check("rst busy", busy, 1'b0);
    rst = 1'b0;
    repeat (3) tick();
    check("ready after mid-tx rst", tx_ready, 1'b1);
    check("rst no rx", n_valid - v0, 0);

`ifdef UPDI_UART_ECHO_CHECK_EN
    // 6b: force the pad low during frame bit 3 (a driven 1)
    c0 = n_coll;
    tx_data = 8'h55; tx_valid = 1'b1;
    tick();
    repeat (49) tick();
    force_low = 1'b1;
    repeat (16) tick();
    force_low = 1'b0;
    wait_oe_low("echo tx ends");
    tick();
    check("echo collision once", n_coll - c0, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
